fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage of the unpipelined core. It is the producer of the `instr`/`pc` stream that decode consumes.
- Owns the architectural fetch PC and issues single-outstanding requests to instruction memory. Memory latency is variable (stall/done style).
- Presents each fetched instruction to decode with a valid/ready handshake.
- Accepts taken-branch/jump redirects and halt from downstream.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.
- NOP_INSTR, 16'h0800, value driven on `instr` when no valid instruction is held.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  request valid to instruction memory
- imem_addr  output  16  request address (= fetch_pc)
- imem_stall  input  1  memory busy; request not accepted this cycle
- imem_done  input  1  read data valid this cycle
- imem_rdata  input  16  instruction word, valid with `imem_done`
- instr  output  16  fetched instruction to decode
- pc  output  16  address of `instr`
- next_pc_basic  output  16  pc + 2, mod 2^16
- instr_valid  output  1  `instr`/`pc` hold a live instruction
- instr_ready  input  1  decode consumes `instr` this cycle
- redirect  input  1  single-cycle pulse: change flow to `redirect_pc`
- redirect_pc  input  16  redirect target
- halt  input  1  current instruction is HALT (meaningful only at handshake)
- halted  output  1  fetch stopped permanently until reset
- err  output  1  sticky protocol/alignment error

Behaviour:
- Reset (async, rst_n=0):
  - state=REQ, fetch_pc=RESET_PC.
  - instr=NOP_INSTR, pc=RESET_PC, instr_valid=0, halted=0, err=0, imem_req=0.
- Request acceptance: a request is accepted in a cycle with imem_req=1 and imem_stall=0. At most one request is outstanding.
- imem_done may assert in the acceptance cycle (0-latency hit) or any later cycle.
- imem_req = (state==REQ) && !redirect. imem_addr = fetch_pc, held stable while stalled.
- FSM states: REQ, WAIT, FULL, DRAIN, HALTED.
- REQ:
  - Stalled: remain in REQ.
  - Accepted with done in the same cycle: capture the response (see below), go FULL.
  - Accepted without done: go WAIT.
- WAIT: on imem_done, capture the response, go FULL.
- Capture action: instr<=imem_rdata, pc<=fetch_pc, instr_valid<=1, fetch_pc<=fetch_pc+2.
- FULL:
  - Hold instr/pc/instr_valid stable while instr_ready=0.
  - On instr_ready=1 with halt=0: instr_valid<=0, instr<=NOP_INSTR, go REQ. The next request issues the following cycle.
  - On instr_ready=1 with halt=1: go HALTED.
- Redirect has priority over all transitions except from HALTED:
  - Always: fetch_pc<=redirect_pc, instr_valid<=0, instr<=NOP_INSTR.
  - From REQ or FULL: go REQ (no request issued in the redirect cycle).
  - From WAIT without imem_done: go DRAIN.
  - From WAIT with imem_done in the same cycle: discard the data, go REQ.
- DRAIN: on imem_done, discard imem_rdata and go REQ. A redirect while in DRAIN updates fetch_pc and stays in DRAIN.
- HALTED: halted=1, imem_req=0, instr_valid=0. Redirect and halt are ignored. Only reset exits this state.
- Unexpected imem_done in REQ-without-acceptance, FULL or HALTED: ignored, err<=1 (sticky until reset).
- Arithmetic: all PC math is 16-bit modulo; 16'hFFFE+2=16'h0000.
- next_pc_basic = pc+2 combinationally.
- Latency: with a 0-latency memory and instr_ready held 1, one instruction every 2 cycles.

Optional Feature:
- FETCH_ALIGN_CHK_EN defined:
  - In REQ, if fetch_pc[0]=1, no request is issued.
  - err<=1, and the state goes HALTED next cycle.
- FETCH_ALIGN_CHK_EN not defined: no check. An odd fetch_pc is driven on imem_addr unchanged.

Test Plan:
- Reset release, 0-latency memory returning addr^16'hA5A5, instr_ready=1 → imem_addr 0x0000, 0x0002, 0x0004; instr 0xA5A5, 0xA5A7, 0xA5A1; pc matches; next_pc_basic = pc+2.
- imem_stall=1 for 3 cycles on first request → imem_req=1 and imem_addr=0x0000 stable for 4 cycles; exactly one capture follows.
- 2-cycle-latency memory; redirect to 0x0100 while in WAIT for 0x0002 → returned word discarded, instr_valid stays 0, next imem_addr=0x0100, delivered pc=0x0100.
- instr_ready=0 for 5 cycles with instr_valid=1 → instr/pc unchanged, imem_req=0 throughout; ready=1 → next request at pc+2.
- Handshake with halt=1 → halted=1 next cycle, imem_req=0 for 20 cycles, redirect to 0x0040 ignored; rst_n pulse → fetch restarts at 0x0000.
- Redirect to 0xFFFE → pc=0xFFFE, next_pc_basic=0x0000, next imem_addr=0x0000. With FETCH_ALIGN_CHK_EN, redirect to 0x0101 → no request, err=1, halted=1.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one outstanding imem request at a time,
// and hands instructions to decode over valid/ready. Optional macro: FETCH_ALIGN_CHK_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_stall,
    input  logic        imem_done,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic [15:0] next_pc_basic,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        err
);

    typedef enum logic [2:0] {REQ, WAIT, FULL, DRAIN, HALTED} state_t;

    state_t      state;
    logic [15:0] fetch_pc;
    logic        misaligned;
    logic        accept;

`ifdef FETCH_ALIGN_CHK_EN
    assign misaligned = fetch_pc[0];
`else
    assign misaligned = 1'b0;
`endif

    // Request is held low during reset even though the state register already reads REQ.
    assign imem_req      = rst_n && (state == REQ) && !redirect && !misaligned;
    assign accept        = imem_req && !imem_stall;
    assign imem_addr     = fetch_pc;
    assign next_pc_basic = pc + 16'd2;
    assign halted        = (state == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= REQ;
            fetch_pc    <= RESET_PC;
            instr       <= NOP_INSTR;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                REQ: begin
                    if (imem_done && !accept)
                        err <= 1'b1;
                    if (redirect) begin
                        fetch_pc    <= redirect_pc;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                    end else if (misaligned) begin
                        err   <= 1'b1;
                        state <= HALTED;
                    end else if (accept) begin
                        if (imem_done) begin
                            instr       <= imem_rdata;
                            pc          <= fetch_pc;
                            instr_valid <= 1'b1;
                            fetch_pc    <= fetch_pc + 16'd2;
                            state       <= FULL;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc    <= redirect_pc;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        // The in-flight word belongs to the old path; drain it if not already back.
                        state       <= imem_done ? REQ : DRAIN;
                    end else if (imem_done) begin
                        instr       <= imem_rdata;
                        pc          <= fetch_pc;
                        instr_valid <= 1'b1;
                        fetch_pc    <= fetch_pc + 16'd2;
                        state       <= FULL;
                    end
                end
                FULL: begin
                    if (imem_done)
                        err <= 1'b1;
                    if (redirect) begin
                        fetch_pc    <= redirect_pc;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        state       <= REQ;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                        state       <= halt ? HALTED : REQ;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        fetch_pc    <= redirect_pc;
                        instr_valid <= 1'b0;
                        instr       <= NOP_INSTR;
                    end
                    if (imem_done)
                        state <= REQ;
                end
                HALTED: begin
                    if (imem_done)
                        err <= 1'b1;
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule
